// File: rtl/shift_arb_pkg.sv
// Shared types for the shift arbiter: port id, in-flight tag, sizing limits.
package shift_arb_pkg;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned NUM_PORTS   = 2;

  typedef logic [0:0] port_id_t;

  // One entry of the tag delay line: marks which port a datapath slot belongs to.
  typedef struct packed {
    logic     valid;
    port_id_t id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/shift_arbiter_if.sv
// Client-side request/response bundle of the two-port shift arbiter.
interface shift_arbiter_if;

  logic [1:0]  req;
  logic [7:0]  n0;
  logic [7:0]  n1;
  logic [31:0] dataa0;
  logic [31:0] dataa1;
  logic [31:0] datab0;
  logic [31:0] datab1;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [31:0] result;

  modport master (
    output req, n0, n1, dataa0, dataa1, datab0, datab1,
    input  grant, done, result
  );

  modport slave (
    input  req, n0, n1, dataa0, dataa1, datab0, datab1,
    output grant, done, result
  );

endinterface

// File: rtl/shift_arb_tag_pipe.sv
// Tag delay line that tracks which port owns each slot of the external shift pipeline.
module shift_arb_tag_pipe
  import shift_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [LATENCY];
  tag_t stage_d [LATENCY];

  // Shift one stage per enabled cycle; hold everything otherwise.
  always_comb begin
    stage_d = stage_q;
    if (clk_en) begin
      stage_d[0] = tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[LATENCY-1];

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared, fixed-latency shift datapath.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  shift_arbiter_if.slave    bus,
  output logic [7:0]        sh_n,
  output logic [31:0]       sh_dataa,
  output logic [31:0]       sh_datab,
  input  logic [31:0]       sh_result
);

  logic [1:0] busy_q;
  logic [1:0] busy_d;
  port_id_t   last_id_q;
  port_id_t   last_id_d;
  logic       active;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] done;
  tag_t       tag_in;
  tag_t       tag_out;

  // Reset is gated in combinationally so outputs are quiet during reset cycles too.
  assign active = clk_en && !reset;

  // Round-robin pick between eligible ports; ties go to the port not granted last.
  always_comb begin
    eligible = active ? (bus.req & ~busy_q) : 2'b00;
    grant    = 2'b00;
    if (eligible == 2'b11) begin
      grant = (last_id_q == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
  end

  // Issue the winner's operands to the datapath and tag the slot.
  always_comb begin
    sh_n          = '0;
    sh_dataa      = '0;
    sh_datab      = '0;
    tag_in.valid  = |grant;
    tag_in.id     = grant[1];
    if (grant[0]) begin
      sh_n     = bus.n0;
      sh_dataa = bus.dataa0;
      sh_datab = bus.datab0;
    end else if (grant[1]) begin
      sh_n     = bus.n1;
      sh_dataa = bus.dataa1;
      sh_datab = bus.datab1;
    end
  end

  // Retire the slot leaving the pipeline and return its result.
  always_comb begin
    done = 2'b00;
    if (active && tag_out.valid) begin
      done[tag_out.id] = 1'b1;
    end
  end

  // Busy/round-robin bookkeeping; grant and done always name different ports.
  always_comb begin
    busy_d    = (busy_q | grant) & ~done;
    last_id_d = (|grant) ? port_id_t'(grant[1]) : last_id_q;
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 2'b00;
      last_id_q <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      last_id_q <= last_id_d;
    end
  end

  assign bus.grant  = grant;
  assign bus.done   = done;
  assign bus.result = (|done) ? sh_result : '0;

  shift_arb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with LATENCY=3.
module tb_shift_arbiter;

  localparam logic [7:0]  N0 = 8'h11;
  localparam logic [31:0] A0 = 32'hA0A0_0001;
  localparam logic [31:0] B0 = 32'h0000_0005;
  localparam logic [7:0]  N1 = 8'h22;
  localparam logic [31:0] A1 = 32'hB1B1_0002;
  localparam logic [31:0] B1 = 32'h0000_0007;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic [7:0]  sh_n;
  logic [31:0] sh_dataa;
  logic [31:0] sh_datab;
  logic [31:0] sh_result;

  int vectors;
  int miscompares;

  shift_arbiter_if bus ();

  shift_arbiter #(
    .LATENCY (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .bus       (bus),
    .sh_n      (sh_n),
    .sh_dataa  (sh_dataa),
    .sh_datab  (sh_datab),
    .sh_result (sh_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset   = 1'b1;
    clk_en  = 1'b1;
    bus.req = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    clk_en    = 1'b1;
    bus.req   = 2'b11;
    sh_result = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors += 3;
      if (bus.grant !== 2'b00 || bus.done !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_gd c%0d: grant=%b done=%b, want 00/00", c, bus.grant, bus.done);
      end
      if (bus.result !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_result c%0d: got %h want 0", c, bus.result);
      end
      if ({sh_n, sh_dataa, sh_datab} !== 72'h0) begin
        miscompares++;
        $display("FAIL reset_sh c%0d: got %h want 0", c, {sh_n, sh_dataa, sh_datab});
      end
      @(posedge clk); #1;
    end
    reset   = 1'b0;
    bus.req = 2'b00;
    #1;
    vectors++;
    if (bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_after: grant=%b done=%b result=%h, want 00/00/0", bus.grant, bus.done, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [1:0] rq [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] eg [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] ed [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [71:0] exp_sh;
    logic [31:0] exp_res;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.req   = rq[c];
      clk_en    = 1'b1;
      sh_result = 32'h1111_0000 | 32'(c);
      #1;
      exp_sh  = (eg[c] == 2'b01) ? {N0, A0, B0} : (eg[c] == 2'b10) ? {N1, A1, B1} : 72'h0;
      exp_res = (ed[c] != 2'b00) ? sh_result : 32'h0;
      vectors += 4;
      if (bus.grant !== eg[c]) begin
        miscompares++;
        $display("FAIL single_grant c%0d: got %b want %b", c, bus.grant, eg[c]);
      end
      if (bus.done !== ed[c]) begin
        miscompares++;
        $display("FAIL single_done c%0d: got %b want %b", c, bus.done, ed[c]);
      end
      if (bus.result !== exp_res) begin
        miscompares++;
        $display("FAIL single_result c%0d: got %h want %h", c, bus.result, exp_res);
      end
      if ({sh_n, sh_dataa, sh_datab} !== exp_sh) begin
        miscompares++;
        $display("FAIL single_sh c%0d: got %h want %h", c, {sh_n, sh_dataa, sh_datab}, exp_sh);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
    logic [1:0] ed [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [71:0] exp_sh;
    logic [31:0] exp_res;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.req   = 2'b11;
      clk_en    = 1'b1;
      sh_result = 32'h2222_0000 | 32'(c);
      #1;
      exp_sh  = (eg[c] == 2'b01) ? {N0, A0, B0} : (eg[c] == 2'b10) ? {N1, A1, B1} : 72'h0;
      exp_res = (ed[c] != 2'b00) ? sh_result : 32'h0;
      vectors += 4;
      if (bus.grant !== eg[c]) begin
        miscompares++;
        $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grant, eg[c]);
      end
      if (bus.done !== ed[c]) begin
        miscompares++;
        $display("FAIL rr_done c%0d: got %b want %b", c, bus.done, ed[c]);
      end
      if (bus.result !== exp_res) begin
        miscompares++;
        $display("FAIL rr_result c%0d: got %h want %h", c, bus.result, exp_res);
      end
      if ({sh_n, sh_dataa, sh_datab} !== exp_sh) begin
        miscompares++;
        $display("FAIL rr_sh c%0d: got %h want %h", c, {sh_n, sh_dataa, sh_datab}, exp_sh);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clk_en_stall();
    logic [1:0] rq [11] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic       en [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] eg [11] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] ed [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [71:0] exp_sh;
    logic [31:0] exp_res;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      bus.req   = rq[c];
      clk_en    = en[c];
      sh_result = 32'h3333_0000 | 32'(c);
      #1;
      exp_sh  = (eg[c] == 2'b01) ? {N0, A0, B0} : (eg[c] == 2'b10) ? {N1, A1, B1} : 72'h0;
      exp_res = (ed[c] != 2'b00) ? sh_result : 32'h0;
      vectors += 4;
      if (bus.grant !== eg[c]) begin
        miscompares++;
        $display("FAIL stall_grant c%0d: got %b want %b", c, bus.grant, eg[c]);
      end
      if (bus.done !== ed[c]) begin
        miscompares++;
        $display("FAIL stall_done c%0d: got %b want %b", c, bus.done, ed[c]);
      end
      if (bus.result !== exp_res) begin
        miscompares++;
        $display("FAIL stall_result c%0d: got %h want %h", c, bus.result, exp_res);
      end
      if ({sh_n, sh_dataa, sh_datab} !== exp_sh) begin
        miscompares++;
        $display("FAIL stall_sh c%0d: got %h want %h", c, {sh_n, sh_dataa, sh_datab}, exp_sh);
      end
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [1:0] rq [13] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic       rs [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] eg [13] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [71:0] exp_sh;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bus.req   = rq[c];
      reset     = rs[c];
      clk_en    = 1'b1;
      sh_result = 32'h4444_0000 | 32'(c);
      #1;
      exp_sh = (eg[c] == 2'b01) ? {N0, A0, B0} : 72'h0;
      vectors += 4;
      if (bus.grant !== eg[c]) begin
        miscompares++;
        $display("FAIL midrst_grant c%0d: got %b want %b", c, bus.grant, eg[c]);
      end
      if (bus.done !== 2'b00) begin
        miscompares++;
        $display("FAIL midrst_done c%0d: got %b want 00", c, bus.done);
      end
      if (bus.result !== 32'h0) begin
        miscompares++;
        $display("FAIL midrst_result c%0d: got %h want 0", c, bus.result);
      end
      if ({sh_n, sh_dataa, sh_datab} !== exp_sh) begin
        miscompares++;
        $display("FAIL midrst_sh c%0d: got %h want %h", c, {sh_n, sh_dataa, sh_datab}, exp_sh);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_through_done();
    logic [1:0] eg [8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] ed [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [31:0] exp_res;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.req   = 2'b01;
      clk_en    = 1'b1;
      sh_result = 32'h5555_0000 | 32'(c);
      #1;
      exp_res = (ed[c] != 2'b00) ? sh_result : 32'h0;
      vectors += 3;
      if (bus.grant !== eg[c]) begin
        miscompares++;
        $display("FAIL hold_grant c%0d: got %b want %b", c, bus.grant, eg[c]);
      end
      if (bus.done !== ed[c]) begin
        miscompares++;
        $display("FAIL hold_done c%0d: got %b want %b", c, bus.done, ed[c]);
      end
      if (bus.result !== exp_res) begin
        miscompares++;
        $display("FAIL hold_result c%0d: got %h want %h", c, bus.result, exp_res);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clk_en      = 1'b0;
    sh_result   = '0;
    bus.req     = 2'b00;
    bus.n0      = N0;
    bus.dataa0  = A0;
    bus.datab0  = B0;
    bus.n1      = N1;
    bus.dataa1  = A1;
    bus.datab1  = B1;

    test_reset();
    test_single();
    test_round_robin();
    test_clk_en_stall();
    test_mid_reset();
    test_hold_through_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
